// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
package wb_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first requester above last, wrapping.
module rr_pick
  import wb_rr_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_i) + k) % N;
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter with per-transfer watchdog.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_MASTERS*32-1:0] wbm_adr_i,
  input  logic [NUM_MASTERS*32-1:0] wbm_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  output logic [31:0]               wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [31:0]               wbs_adr_o,
  output logic [31:0]               wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  input  logic [31:0]               wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      timeout_o
);

  localparam int IW = clog2(NUM_MASTERS);
  localparam int CW = (TIMEOUT_CYCLES > 0) ?
                      clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);
  localparam logic          WD_EN = (TIMEOUT_CYCLES != 0);

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          last_q, last_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic                   pick_vld;
  logic                   busy, g_cyc, g_stb;
  logic                   waiting, abort;

  rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req_i  (wbm_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  assign busy    = (state_q == ST_BUSY);
  assign g_cyc   = wbm_cyc_i[gidx_q];
  assign g_stb   = wbm_stb_i[gidx_q];
  assign waiting = busy & g_stb & ~wbs_ack_i & ~wbs_err_i;
  // Ack or slave err in the same cycle pre-empts the abort.
  assign abort   = WD_EN & waiting & (cnt_q == TMO);

  assign wbm_dat_o = wbs_dat_i;
  assign grant_o   = grant_q;
  assign timeout_o = abort;

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    if (busy) begin
      wbs_adr_o = wbm_adr_i[32*gidx_q +: 32];
      wbs_dat_o = wbm_dat_i[32*gidx_q +: 32];
      wbs_sel_o = wbm_sel_i[4*gidx_q +: 4];
      wbs_we_o  = wbm_we_i[gidx_q];
      wbs_cyc_o = g_cyc & ~abort;
      wbs_stb_o = g_stb & ~abort;
      wbm_ack_o[gidx_q] = wbs_ack_i & g_stb;
      wbm_err_o[gidx_q] = (wbs_err_i & g_stb) | abort;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_BUSY;
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          last_d  = pick_idx;
        end
      end
      ST_BUSY: begin
        if (!g_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (waiting && !abort &&
                     cnt_q != TMO) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (2 masters, timeout 4).
module tb_wb_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [63:0] adr, dat;
  logic [7:0]  sel;
  logic [1:0]  we, cyc, stb;
  logic [31:0] m_dat;
  logic [1:0]  m_ack, m_err;
  logic [31:0] s_adr, s_dat;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb;
  logic [31:0] s_dat_i;
  logic        s_ack, s_err;
  logic [1:0]  grant;
  logic        tmo;

  int n_tests;
  int n_fail;

  wb_rr_arbiter #(
    .NUM_MASTERS    (2),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbm_adr_i (adr),
    .wbm_dat_i (dat),
    .wbm_sel_i (sel),
    .wbm_we_i  (we),
    .wbm_cyc_i (cyc),
    .wbm_stb_i (stb),
    .wbm_dat_o (m_dat),
    .wbm_ack_o (m_ack),
    .wbm_err_o (m_err),
    .wbs_adr_o (s_adr),
    .wbs_dat_o (s_dat),
    .wbs_sel_o (s_sel),
    .wbs_we_o  (s_we),
    .wbs_cyc_o (s_cyc),
    .wbs_stb_o (s_stb),
    .wbs_dat_i (s_dat_i),
    .wbs_ack_i (s_ack),
    .wbs_err_i (s_err),
    .grant_o   (grant),
    .timeout_o (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    adr     = {32'h0000_0200, 32'h0000_0100};
    dat     = {32'h2222_2222, 32'h1111_1111};
    sel     = 8'hCF;
    we      = 2'b10;
    cyc     = 2'b00;
    stb     = 2'b00;
    s_dat_i = '0;
    s_ack   = 1'b0;
    s_err   = 1'b0;

    // reset state
    do_reset();
    settle();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_cyc", 32'(s_cyc), 32'h0);
    chk("rst_tmo", 32'(tmo), 32'h0);

    // single request from m0
    cyc = 2'b01;
    stb = 2'b01;
    settle();
    chk("s_idle_stb", 32'(s_stb), 32'h0);
    step();
    chk("s_grant", 32'(grant), 32'h1);
    chk("s_stb", 32'(s_stb), 32'h1);
    chk("s_adr", s_adr, 32'h100);
    chk("s_sel", 32'(s_sel), 32'hF);
    chk("s_we", 32'(s_we), 32'h0);
    s_ack   = 1'b1;
    s_dat_i = 32'hDEAD_BEEF;
    settle();
    chk("s_ack", 32'(m_ack), 32'h1);
    chk("s_rdat", m_dat, 32'hDEAD_BEEF);
    step();
    s_ack = 1'b0;
    cyc   = 2'b00;
    stb   = 2'b00;
    settle();
    chk("s_drop_cyc", 32'(s_cyc), 32'h0);
    step();
    chk("s_rel", 32'(grant), 32'h0);

    // contention right after reset
    do_reset();
    cyc = 2'b11;
    stb = 2'b11;
    step();
    chk("c_first", 32'(grant), 32'h1);
    s_ack = 1'b1;
    settle();
    chk("c_ack_m0", 32'(m_ack), 32'h1);
    step();
    s_ack = 1'b0;
    cyc   = 2'b10;
    stb   = 2'b10;
    step();
    chk("c_gap_grant", 32'(grant), 32'h0);
    chk("c_gap_cyc", 32'(s_cyc), 32'h0);
    step();
    chk("c_second", 32'(grant), 32'h2);
    chk("c_adr_m1", s_adr, 32'h200);
    chk("c_dat_m1", s_dat, 32'h2222_2222);
    chk("c_we_m1", 32'(s_we), 32'h1);
    s_ack = 1'b1;
    settle();
    chk("c_ack_m1", 32'(m_ack), 32'h2);
    step();
    s_ack = 1'b0;
    cyc   = 2'b00;
    stb   = 2'b00;
    step();
    cyc = 2'b11;
    stb = 2'b11;
    step();
    chk("c_rotate", 32'(grant), 32'h1);

    // back-to-back beats by m1
    cyc = 2'b00;
    stb = 2'b00;
    step();
    cyc = 2'b10;
    stb = 2'b10;
    step();
    s_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      settle();
      chk($sformatf("b_grant%0d", b), 32'(grant), 32'h2);
      chk($sformatf("b_ack%0d", b), 32'(m_ack), 32'h2);
      chk($sformatf("b_cyc%0d", b), 32'(s_cyc), 32'h1);
      step();
    end
    s_ack = 1'b0;
    cyc   = 2'b00;
    stb   = 2'b00;
    step();
    step();

    // watchdog abort
    cyc = 2'b01;
    stb = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("t_wait%0d", c), 32'(tmo), 32'h0);
    end
    chk("t_stb_live", 32'(s_stb), 32'h1);
    step();
    chk("t_tmo", 32'(tmo), 32'h1);
    chk("t_err", 32'(m_err), 32'h1);
    chk("t_cyc", 32'(s_cyc), 32'h0);
    chk("t_stb", 32'(s_stb), 32'h0);
    step();
    chk("t_after", 32'(tmo), 32'h0);
    chk("t_held", 32'(grant), 32'h1);
    chk("t_recyc", 32'(s_cyc), 32'h1);
    for (int c = 0; c < 4; c++) step();
    s_ack = 1'b1;
    settle();
    chk("t_ack_win", 32'(m_ack), 32'h1);
    chk("t_ack_noerr", 32'(m_err), 32'h0);
    chk("t_ack_notmo", 32'(tmo), 32'h0);
    step();
    s_ack = 1'b0;
    cyc   = 2'b00;
    stb   = 2'b00;
    step();
    step();

    // reset in the middle of an m1 cycle
    cyc = 2'b10;
    stb = 2'b10;
    step();
    chk("r_m1", 32'(grant), 32'h2);
    rst = 1'b1;
    cyc = 2'b11;
    stb = 2'b11;
    step();
    rst = 1'b0;
    settle();
    chk("r_grant", 32'(grant), 32'h0);
    chk("r_cyc", 32'(s_cyc), 32'h0);
    step();
    chk("r_m0_wins", 32'(grant), 32'h1);

    // slave err passes through
    s_err = 1'b1;
    settle();
    chk("e_err", 32'(m_err), 32'h1);
    chk("e_notmo", 32'(tmo), 32'h0);
    chk("e_noack", 32'(m_ack), 32'h0);
    step();
    s_err = 1'b0;
    cyc   = 2'b00;
    stb   = 2'b00;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
